// File: rtl/vga_timing_gen.sv
// vga_timing_gen: generic VGA timing plus background / border / movable-box overlay.
// Optional build macro VGA_BOUNCE_EN makes the box bounce by one pixel per frame.
module vga_timing_gen #(
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter int SYNC_POL = 0,
  parameter int CW       = 4,
  parameter int BORDER_W = 8,
  parameter int BOX_W    = 32,
  parameter logic [3*CW-1:0] BG_COLOR     = 12'h00F,
  parameter logic [3*CW-1:0] BORDER_COLOR = 12'h0F0,
  parameter logic [3*CW-1:0] BOX_COLOR    = 12'hF0F
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pos_valid,
  output logic          pos_ready,
  input  logic [10:0]   pos_x,
  input  logic [9:0]    pos_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [10:0]   xpos,
  output logic [9:0]    ypos,
  output logic          frame_start,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b
);

  localparam logic [11:0] H_TOTAL  = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_SYNC_C = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_S  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_E  = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_TOTAL  = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_C = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_S  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_E  = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [11:0] BORDER_C = 12'(BORDER_W);
  localparam logic [11:0] BORDER_R = 12'(H_ACTIVE - BORDER_W);
  localparam logic [11:0] BORDER_B = 12'(V_ACTIVE - BORDER_W);
  localparam logic [11:0] BOX_C    = 12'(BOX_W);
  localparam logic [10:0] BOX_X0   = 11'(H_ACTIVE / 2 - BOX_W / 2);
  localparam logic [9:0]  BOX_Y0   = 10'(V_ACTIVE / 2 - BOX_W / 2);
  localparam logic        SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PEND  = 2'd1,
    ST_LOAD  = 2'd2
  } hs_state_t;

  logic [11:0]    h_cnt_r;
  logic [10:0]    v_cnt_r;
  logic [10:0]    box_x_r;
  logic [9:0]     box_y_r;
  logic [10:0]    sh_x_r;
  logic [9:0]     sh_y_r;
  hs_state_t      state_r;
  hs_state_t      state_nxt_s;
  logic           boundary_s;
  logic           cap_s;
  logic           load_s;
  logic           act_s;
  logic [11:0]    x_s;
  logic [11:0]    y_s;
  logic           in_box_s;
  logic           in_border_s;
  logic [3*CW-1:0] color_s;

  assign boundary_s = (h_cnt_r == 12'd0) && (v_cnt_r == 11'd0);

  // Horizontal / vertical raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 11'd0;
    end else if (h_cnt_r == H_TOTAL - 12'd1) begin
      h_cnt_r <= 12'd0;
      if (v_cnt_r == V_TOTAL - 11'd1) begin
        v_cnt_r <= 11'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 11'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 12'd1;
    end
  end

  // Handshake state register; pos_ready follows the next state so it is a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_READY;
      pos_ready <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      pos_ready <= (state_nxt_s == ST_READY);
    end
  end

  // Handshake next-state logic: a pending position waits for a later frame boundary
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_READY: begin
        if (pos_valid) state_nxt_s = ST_PEND;
        else           state_nxt_s = ST_READY;
      end
      ST_PEND: begin
        if (boundary_s) state_nxt_s = ST_LOAD;
        else            state_nxt_s = ST_PEND;
      end
      ST_LOAD:  state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_READY;
    endcase
  end

  // Handshake actions: capture into the shadow, load the live box
  always_comb begin
    cap_s  = (state_r == ST_READY) && pos_valid;
    load_s = (state_r == ST_PEND) && boundary_s;
  end

`ifdef VGA_BOUNCE_EN
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - BOX_W);
  logic        dir_x_r;
  logic        dir_y_r;
  logic        step_dx_s;
  logic        step_dy_s;
  logic [10:0] step_x_s;
  logic [9:0]  step_y_s;

  // Bounce step: reverse a direction before the box would leave the active area
  always_comb begin
    if (dir_x_r && (box_x_r >= X_MAX))        step_dx_s = 1'b0;
    else if (!dir_x_r && (box_x_r == 11'd0))  step_dx_s = 1'b1;
    else                                      step_dx_s = dir_x_r;
    if (dir_y_r && (box_y_r >= Y_MAX))        step_dy_s = 1'b0;
    else if (!dir_y_r && (box_y_r == 10'd0))  step_dy_s = 1'b1;
    else                                      step_dy_s = dir_y_r;
    step_x_s = step_dx_s ? (box_x_r + 11'd1) : (box_x_r - 11'd1);
    step_y_s = step_dy_s ? (box_y_r + 10'd1) : (box_y_r - 10'd1);
  end
`endif

  // Shadow and live box position; the live box changes only at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x_r  <= 11'd0;
      sh_y_r  <= 10'd0;
      box_x_r <= BOX_X0;
      box_y_r <= BOX_Y0;
`ifdef VGA_BOUNCE_EN
      dir_x_r <= 1'b1;
      dir_y_r <= 1'b1;
`endif
    end else begin
      if (cap_s) begin
        sh_x_r <= pos_x;
        sh_y_r <= pos_y;
      end
      if (load_s) begin
        box_x_r <= sh_x_r;
        box_y_r <= sh_y_r;
      end
`ifdef VGA_BOUNCE_EN
      else if (boundary_s) begin
        box_x_r <= step_x_s;
        box_y_r <= step_y_s;
        dir_x_r <= step_dx_s;
        dir_y_r <= step_dy_s;
      end
`endif
    end
  end

  // Pixel classification; box compares are 12 bits wide so a clipped box never wraps
  always_comb begin
    act_s = (h_cnt_r >= H_ACT_S) && (h_cnt_r < H_ACT_E) &&
            (v_cnt_r >= V_ACT_S) && (v_cnt_r < V_ACT_E);
    x_s = h_cnt_r - H_ACT_S;
    y_s = {1'b0, v_cnt_r} - {1'b0, V_ACT_S};
    in_box_s = (x_s >= {1'b0, box_x_r}) && (x_s < ({1'b0, box_x_r} + BOX_C)) &&
               (y_s >= {2'b00, box_y_r}) && (y_s < ({2'b00, box_y_r} + BOX_C));
    in_border_s = (x_s < BORDER_C) || (x_s >= BORDER_R) ||
                  (y_s < BORDER_C) || (y_s >= BORDER_B);
    if (!act_s)           color_s = '0;
    else if (in_box_s)    color_s = BOX_COLOR;
    else if (in_border_s) color_s = BORDER_COLOR;
    else                  color_s = BG_COLOR;
  end

  // Registered video outputs, one clock behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      xpos        <= 11'd0;
      ypos        <= 10'd0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      hsync       <= (h_cnt_r < H_SYNC_C) ? SYNC_ON : ~SYNC_ON;
      vsync       <= (v_cnt_r < V_SYNC_C) ? SYNC_ON : ~SYNC_ON;
      de          <= act_s;
      xpos        <= act_s ? x_s[10:0] : 11'd0;
      ypos        <= act_s ? y_s[9:0] : 10'd0;
      frame_start <= boundary_s;
      vga_r       <= color_s[3*CW-1:2*CW];
      vga_g       <= color_s[2*CW-1:CW];
      vga_b       <= color_s[CW-1:0];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 52x36 raster (40x30 active).
// A second instance checks inverted sync polarity and 8-bit colour channels.
module tb_vga_timing_gen;

  localparam int HS = 4, HB = 4, HA = 40, HF = 4;
  localparam int VS = 2, VB = 2, VA = 30, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] C_BG = 12'h00F, C_BRD = 12'h0F0, C_BOX = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pos_valid = 1'b0;
  logic [10:0] pos_x = 11'd0;
  logic [9:0]  pos_y = 10'd0;

  logic        pos_ready, hsync, vsync, de, frame_start;
  logic [10:0] xpos;
  logic [9:0]  ypos;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [11:0] rgb;

  logic        pos_ready_1, hsync_1, vsync_1, de_1, frame_start_1;
  logic [10:0] xpos_1;
  logic [9:0]  ypos_1;
  logic [7:0]  vga_r_1, vga_g_1, vga_b_1;
  logic [23:0] rgb_1;

  int n_chk = 0, n_err = 0, n = 0;
  int hs_lo = 0, vs_lo = 0, de_hi = 0, fs_cnt = 0, hs1_hi = 0;

  assign rgb   = {vga_r, vga_g, vga_b};
  assign rgb_1 = {vga_r_1, vga_g_1, vga_b_1};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(0), .CW(4), .BORDER_W(2), .BOX_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_x(pos_x), .pos_y(pos_y), .hsync(hsync), .vsync(vsync), .de(de),
    .xpos(xpos), .ypos(ypos), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SYNC_POL(1), .CW(8), .BORDER_W(2), .BOX_W(8),
    .BG_COLOR(24'h0000FF), .BORDER_COLOR(24'h00FF00), .BOX_COLOR(24'hFF00FF)
  ) dut_w8 (
    .clk(clk), .rst_n(rst_n), .pos_valid(pos_valid), .pos_ready(pos_ready_1),
    .pos_x(pos_x), .pos_y(pos_y), .hsync(hsync_1), .vsync(vsync_1), .de(de_1),
    .xpos(xpos_1), .ypos(ypos_1), .frame_start(frame_start_1),
    .vga_r(vga_r_1), .vga_g(vga_g_1), .vga_b(vga_b_1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Outputs after the n-th edge since reset release show raster index n-1.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic int pix(input int x, input int y);
    return (y + VS + VB) * HT + x + HS + HB;
  endfunction

  task automatic goto_idx(input int t);
    for (int i = 0; i <= FRAME && ((n - 1) % FRAME) != t; i++) tick();
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input logic [11:0] exp);
    goto_idx(pix(x, y));
    chk(tag, rgb, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_de", de, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_xy", {xpos, ypos}, 21'd0);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_ready", pos_ready, 1'b1);
    chk("rst_hsync_pol1", hsync_1, 1'b0);
    chk("rst_vsync_pol1", vsync_1, 1'b0);
    rst_n = 1'b1;
    n = 0;

    // First frame: sync/de statistics and reset-time picture
    for (int i = 0; i < FRAME; i++) begin
      tick();
      hs_lo  += (hsync == 1'b0) ? 1 : 0;
      vs_lo  += (vsync == 1'b0) ? 1 : 0;
      de_hi  += (de == 1'b1) ? 1 : 0;
      fs_cnt += (frame_start == 1'b1) ? 1 : 0;
      hs1_hi += (hsync_1 == 1'b1) ? 1 : 0;
      if (i == 0) begin
        chk("fs_first", frame_start, 1'b1);
        chk("hsync_first", hsync, 1'b0);
        chk("hsync_first_pol1", hsync_1, 1'b1);
        chk("blank_rgb", rgb, 12'h000);
      end
      if (i == pix(0, 0)) begin
        chk("px_0_0", rgb, C_BRD);
        chk("px_0_0_w8", rgb_1, 24'h00FF00);
        chk("xy_0_0", {xpos, ypos}, 21'd0);
      end
      if (i == pix(20, 15)) begin
        chk("px_centre", rgb, C_BOX);
        chk("xpos_20", xpos, 11'd20);
        chk("ypos_15", ypos, 10'd15);
      end
      if (i == pix(5, 15))  chk("px_bg", rgb, C_BG);
      if (i == pix(16, 11)) chk("box_tl", rgb, C_BOX);
      if (i == pix(23, 18)) chk("box_br", rgb, C_BOX);
      if (i == pix(24, 15)) chk("box_right_out", rgb, C_BG);
      if (i == pix(15, 15)) chk("box_left_out", rgb, C_BG);
      if (i == pix(39, 29)) chk("border_br", rgb, C_BRD);
    end
    chk("hsync_low_cnt", hs_lo, HS * VT);
    chk("vsync_low_cnt", vs_lo, VS * HT);
    chk("de_high_cnt", de_hi, HA * VA);
    chk("fs_cnt", fs_cnt, 1);
    chk("hsync_high_cnt_pol1", hs1_hi, HS * VT);
    tick();
    chk("fs_period", frame_start, 1'b1);

    // Mid-frame offer of (10,20); a second valid while not ready is ignored
    goto_idx(500);
    chk("rdy_before", pos_ready, 1'b1);
    pos_x = 11'd10; pos_y = 10'd20; pos_valid = 1'b1;
    tick();
    chk("rdy_drop", pos_ready, 1'b0);
    pos_x = 11'd30; pos_y = 10'd5;
    repeat (3) tick();
    pos_valid = 1'b0;
    chk("rdy_hold", pos_ready, 1'b0);
    chk_pix("box_same_frame", 20, 15, C_BOX);
    goto_idx(0);
    chk("rdy_at_load", pos_ready, 1'b0);
    tick();
    chk("rdy_back", pos_ready, 1'b1);
    chk_pix("ignored_offer", 30, 5, C_BG);
    chk_pix("old_centre", 20, 15, C_BG);
    chk_pix("new_left_out", 9, 20, C_BG);
    chk_pix("new_tl", 10, 20, C_BOX);
    chk_pix("new_right_out", 18, 20, C_BG);
    chk_pix("new_br", 17, 27, C_BOX);

    // Accept in the boundary cycle itself: loads one frame later; clipped box
    goto_idx(FRAME - 1);
    chk("rdy_pre_boundary", pos_ready, 1'b1);
    pos_x = 11'd36; pos_y = 10'd26; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    chk("rdy_boundary_drop", pos_ready, 1'b0);
    tick();
    chk("no_load_same_boundary", pos_ready, 1'b0);
    chk_pix("box_kept_frame", 10, 20, C_BOX);
    goto_idx(0);
    tick();
    chk("rdy_after_clip_load", pos_ready, 1'b1);
    chk_pix("clip_no_top_wrap", 39, 0, C_BRD);
    chk_pix("clip_left_out", 35, 26, C_BG);
    chk_pix("clip_tl", 36, 26, C_BOX);
    chk_pix("clip_no_left_wrap", 0, 29, C_BRD);
    chk_pix("clip_br", 39, 29, C_BOX);

    // Reset mid-frame with a pending update
    goto_idx(300);
    pos_x = 11'd5; pos_y = 10'd5; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    chk("rdy_pending", pos_ready, 1'b0);
    goto_idx(pix(20, 15));
    chk("de_before_reset", de, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_de", de, 1'b0);
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_xpos", xpos, 11'd0);
    chk("mid_rst_hsync", hsync, 1'b1);
    chk("mid_rst_ready", pos_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    tick();
    chk("restart_fs", frame_start, 1'b1);
    chk_pix("post_rst_centre", 20, 15, C_BOX);
    chk_pix("post_rst_old_clip", 36, 26, C_BG);
    goto_idx(0);
    tick();
    chk("post_rst_ready", pos_ready, 1'b1);
    chk_pix("pending_discarded", 5, 5, C_BG);
    chk_pix("post_rst_centre2", 20, 15, C_BOX);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and overlay renderer for the display path. It replaces fixed 800x600 timing with generic horizontal and vertical timing, configurable sync polarity and an RGB width per channel. It draws a background, an active-area border and a movable filled box. The box position is updated through a valid/ready handshake and takes effect only at frame start, so frames never tear.

Parameters:
H_SYNC, 120, hsync pulse width (clocks)
H_BACK, 64, horizontal back porch (clocks)
H_ACTIVE, 800, visible pixels per line
H_FRONT, 56, horizontal front porch (clocks)
V_SYNC, 6, vsync pulse width (lines)
V_BACK, 23, vertical back porch (lines)
V_ACTIVE, 600, visible lines
V_FRONT, 37, vertical front porch (lines)
SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
CW, 4, bits per colour channel
BORDER_W, 8, border thickness (pixels)
BOX_W, 32, box width and height (pixels)
BG_COLOR, 12'h00F, background {r,g,b}, 3*CW bits
BORDER_COLOR, 12'h0F0, border {r,g,b}
BOX_COLOR, 12'hF0F, box {r,g,b}

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pos_valid  in  1  new box position offered
pos_ready  out  1  block can accept a position
pos_x  in  11  box top-left x, in active coordinates
pos_y  in  10  box top-left y, in active coordinates
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  active-video enable
xpos  out  11  active x (0 when de=0)
ypos  out  10  active y (0 when de=0)
frame_start  out  1  one-clock pulse, first clock of each frame
vga_r  out  CW  red
vga_g  out  CW  green
vga_b  out  CW  blue

Behaviour:
- Timing: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL is the vertical equivalent.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and itself wraps after V_TOTAL-1.
- Sync region: h_cnt < H_SYNC (and v_cnt < V_SYNC for vsync). The output level is SYNC_POL while in the sync region, otherwise ~SYNC_POL.
- Active region: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, with the matching vertical condition.
- Latency: every output is registered and reflects counter state exactly 1 clock earlier.
- frame_start is high in the cycle after h_cnt=0 and v_cnt=0.
- Colour priority, applied only when active: box > border > background. Outside the active region all colour outputs are 0.
- Box region: box_x <= x < box_x+BOX_W and box_y <= y < box_y+BOX_W. Compares use 12-bit sums, so a box partly off-screen is clipped and does not wrap.
- Border region: x < BORDER_W, x >= H_ACTIVE-BORDER_W, y < BORDER_W, or y >= V_ACTIVE-BORDER_W.
- Handshake:
  - A transfer occurs when pos_valid && pos_ready. pos_x and pos_y are captured into a shadow register, and pos_ready drops on the next clock.
  - The live box_x/box_y load from the shadow at the next counter frame boundary (h_cnt=0 and v_cnt=0) that occurs strictly after the accept cycle. pos_ready rises on the clock after that load.
  - An accept in the boundary cycle itself waits one full frame.
  - pos_valid held high while pos_ready=0 has no effect.
- Reset: counters 0, box = (H_ACTIVE/2-BOX_W/2, V_ACTIVE/2-BOX_W/2), no pending update, pos_ready=1. hsync and vsync are ~SYNC_POL; de, frame_start, xpos, ypos and RGB are 0.
- Reset asserted mid-frame discards any pending position and restarts at h_cnt=v_cnt=0.

Optional Feature:
Macro VGA_BOUNCE_EN.
- Defined: at each frame boundary with no pending update, box_x and box_y each step ±1 per frame. A direction reverses when the next step would place the box edge outside 0..H_ACTIVE-BOX_W (or 0..V_ACTIVE-BOX_W). Reset directions are +x and +y. A handshake load overrides the step in that frame, and directions are kept.
- Undefined: the box moves only via the handshake.

Test Plan:
- Defaults, reset release, run 2 frames: hsync low for 120 clocks every 1040; vsync low for 6 lines every 666 lines; de high 800 clocks per line and 600 lines per frame; frame_start period 692640 clocks.
- SYNC_POL=1, CW=8: sync levels inverted; reset hsync=0; colour outputs 8 bits wide.
- Pixel (0,0): border colour 12'h0F0. Pixel (400,300): box colour 12'hF0F at reset. Pixel (100,300): background 12'h00F. Blanking: RGB 0.
- Offer (10,20) mid-frame: pos_ready=0 next clock; box is unchanged this frame; next frame the box covers x 10..41 and y 20..51; pos_ready returns to 1. A second valid while not ready is ignored.
- Offer (790,595): box clipped to x 790..799 and y 595..599 with no wrap to the left or top.
- Assert rst_n low mid-frame with an update pending: outputs return to reset values immediately; the box is back at centre and pos_ready=1.
